// File: rtl/pll_lock_sequencer.sv
// Brings up an EHXPLLL from the reference clock: PLL reset pulse, lock debounce with
// bounded retries, system reset release, lock-loss re-sequencing and phase-step serialisation.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter int unsigned STEP_LOW     = 4,
  parameter int unsigned STEP_GAP     = 8
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_locked,
  output logic       o_pll_reset,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic       o_fault,
  input  logic       i_step_valid,
  output logic       o_step_ready,
  input  logic [1:0] i_step_sel,
  input  logic       i_step_dir,
  output logic [1:0] o_phasesel,
  output logic       o_phasedir,
  output logic       o_phasestep,
  output logic [1:0] o_retry_count,
  output logic [7:0] o_loss_count
);

  localparam int unsigned RW     = $clog2(RST_CYCLES + 1);
  localparam int unsigned TW     = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW     = $clog2(LOCK_STABLE + 1);
  localparam int unsigned PMAX_N = (STEP_LOW > STEP_GAP) ? STEP_LOW : STEP_GAP;
  localparam int unsigned PW     = $clog2(PMAX_N + 1);

  localparam logic [RW-1:0] RMAX  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMAX  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SMAX  = SW'(LOCK_STABLE - 1);
  localparam logic [PW-1:0] LMAX  = PW'(STEP_LOW - 1);
  localparam logic [PW-1:0] GMAX  = PW'(STEP_GAP - 1);
  localparam logic [1:0]    RETRY = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST_PLL, S_WAIT_LOCK, S_STABLE, S_RUN, S_PHASE_LOW, S_PHASE_GAP, S_FAULT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_lock_meta, r_lock_s;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic [SW-1:0] r_scnt, w_scnt_nxt;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic [1:0]    r_retries, w_retries_nxt;
  logic [7:0]    r_loss, w_loss_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic          r_dir, w_dir_nxt;
  logic          w_running, w_lost, w_timeout;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state     <= S_RST_PLL;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_rcnt      <= '0;
      r_tcnt      <= '0;
      r_scnt      <= '0;
      r_pcnt      <= '0;
      r_retries   <= '0;
      r_loss      <= '0;
      r_sel       <= '0;
      r_dir       <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_meta <= i_locked;
      r_lock_s    <= r_lock_meta;
      r_rcnt      <= w_rcnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_scnt      <= w_scnt_nxt;
      r_pcnt      <= w_pcnt_nxt;
      r_retries   <= w_retries_nxt;
      r_loss      <= w_loss_nxt;
      r_sel       <= w_sel_nxt;
      r_dir       <= w_dir_nxt;
    end
  end

  // Step handshake: a request transfers on any edge where i_step_valid && o_step_ready;
  // o_step_ready is high only in RUN, and lock loss in that cycle wins over the request.
  always_comb begin
    w_state_nxt   = r_state;
    w_rcnt_nxt    = r_rcnt;
    w_tcnt_nxt    = r_tcnt;
    w_scnt_nxt    = r_scnt;
    w_pcnt_nxt    = r_pcnt;
    w_retries_nxt = r_retries;
    w_loss_nxt    = r_loss;
    w_sel_nxt     = r_sel;
    w_dir_nxt     = r_dir;
    w_running     = (r_state == S_RUN) || (r_state == S_PHASE_LOW) || (r_state == S_PHASE_GAP);
    w_lost        = w_running && !r_lock_s;
    w_timeout     = (r_tcnt == TMAX);

    if (w_lost) begin
      w_state_nxt = S_RST_PLL;
      w_rcnt_nxt  = '0;
      w_loss_nxt  = (r_loss != 8'hFF) ? r_loss + 8'd1 : r_loss;
    end else begin
      case (r_state)
        S_RST_PLL: begin
          if (r_rcnt == RMAX) begin
            w_state_nxt = S_WAIT_LOCK;
            w_rcnt_nxt  = '0;
            w_tcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + RW'(1);
          end
        end
        S_WAIT_LOCK, S_STABLE: begin
          // tcnt survives STABLE->WAIT_LOCK bounces so lock chatter cannot stretch the timeout
          w_tcnt_nxt = r_tcnt + TW'(1);
          if (w_timeout) begin
            if (r_retries == RETRY) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_retries_nxt = r_retries + 2'd1;
              w_state_nxt   = S_RST_PLL;
              w_rcnt_nxt    = '0;
            end
          end else if (r_state == S_WAIT_LOCK) begin
            if (r_lock_s) begin
              w_state_nxt = S_STABLE;
              w_scnt_nxt  = '0;
            end
          end else if (!r_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
          end else if (r_scnt == SMAX) begin
            w_state_nxt   = S_RUN;
            w_retries_nxt = '0;
          end else begin
            w_scnt_nxt = r_scnt + SW'(1);
          end
        end
        S_RUN: begin
          if (i_step_valid) begin
            w_sel_nxt   = i_step_sel;
            w_dir_nxt   = i_step_dir;
            w_pcnt_nxt  = '0;
            w_state_nxt = S_PHASE_LOW;
          end
        end
        S_PHASE_LOW: begin
          if (r_pcnt == LMAX) begin
            w_pcnt_nxt  = '0;
            w_state_nxt = S_PHASE_GAP;
          end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
          end
        end
        S_PHASE_GAP: begin
          if (r_pcnt == GMAX) begin
            w_pcnt_nxt  = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
          end
        end
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_RST_PLL;
      endcase
    end
  end

  assign o_pll_reset   = (r_state == S_RST_PLL) || (r_state == S_FAULT);
  assign o_sys_reset   = !w_running;
  assign o_ready       = w_running;
  assign o_fault       = (r_state == S_FAULT);
  assign o_step_ready  = (r_state == S_RUN);
  assign o_phasestep   = (r_state != S_PHASE_LOW);
  assign o_phasesel    = r_sel;
  assign o_phasedir    = r_dir;
  assign o_retry_count = r_retries;
  assign o_loss_count  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: stimulus schedules expected output snapshots by
// cycle number; a negedge monitor pops and compares them as the cycles come round.
module tb_pll_lock_sequencer;

  localparam int W = 59;  // {cycle[31:0], tag[7:0], outputs[18:0]}

  logic       clk = 1'b0;
  logic       reset;
  logic       i_locked;
  logic       i_step_valid;
  logic [1:0] i_step_sel;
  logic       i_step_dir;
  logic       o_pll_reset, o_sys_reset, o_ready, o_fault, o_step_ready;
  logic [1:0] o_phasesel;
  logic       o_phasedir, o_phasestep;
  logic [1:0] o_retry_count;
  logic [7:0] o_loss_count;

  logic [31:0]  cyc = '0;
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8),
    .MAX_RETRIES(2), .STEP_LOW(2), .STEP_GAP(3)
  ) dut (
    .i_clk(clk), .reset(reset), .i_locked(i_locked),
    .o_pll_reset(o_pll_reset), .o_sys_reset(o_sys_reset), .o_ready(o_ready),
    .o_fault(o_fault), .i_step_valid(i_step_valid), .o_step_ready(o_step_ready),
    .i_step_sel(i_step_sel), .i_step_dir(i_step_dir), .o_phasesel(o_phasesel),
    .o_phasedir(o_phasedir), .o_phasestep(o_phasestep),
    .o_retry_count(o_retry_count), .o_loss_count(o_loss_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  localparam logic [7:0] T_RST = 8'd1, T_BRING = 8'd2, T_STEP = 8'd3, T_B2B = 8'd4,
                         T_LOSS = 8'd5, T_SAT = 8'd6, T_RGAP = 8'd7, T_CHAT = 8'd8,
                         T_RWAIT = 8'd9, T_TMO = 8'd10, T_FLT = 8'd11;

  function automatic string tag_name(input logic [7:0] t);
    case (t)
      T_RST:   return "reset";
      T_BRING: return "bringup";
      T_STEP:  return "step";
      T_B2B:   return "step_b2b";
      T_LOSS:  return "loss_mid_step";
      T_SAT:   return "loss_sat";
      T_RGAP:  return "reset_in_gap";
      T_CHAT:  return "chatter";
      T_RWAIT: return "reset_in_wait";
      T_TMO:   return "timeout";
      T_FLT:   return "fault";
      default: return "unknown";
    endcase
  endfunction

  // output vector order: pll, sys, ready, fault, step_ready, sel, dir, step, retry, loss
  function automatic logic [18:0] v(input logic pll, sys, rdy, flt, srdy,
                                    input logic [1:0] sel, input logic dir, step,
                                    input logic [1:0] rt, input logic [7:0] loss);
    return {pll, sys, rdy, flt, srdy, sel, dir, step, rt, loss};
  endfunction
  function automatic logic [18:0] rstv(input logic [1:0] rt, input logic [7:0] loss,
                                       input logic [1:0] sel, input logic dir);
    return v(1, 1, 0, 0, 0, sel, dir, 1, rt, loss);
  endfunction
  function automatic logic [18:0] waitv(input logic [1:0] rt, input logic [7:0] loss,
                                        input logic [1:0] sel, input logic dir);
    return v(0, 1, 0, 0, 0, sel, dir, 1, rt, loss);
  endfunction
  function automatic logic [18:0] runv(input logic [7:0] loss, input logic [1:0] sel,
                                       input logic dir);
    return v(0, 0, 1, 0, 1, sel, dir, 1, 2'd0, loss);
  endfunction
  function automatic logic [18:0] lowv(input logic [7:0] loss, input logic [1:0] sel,
                                       input logic dir);
    return v(0, 0, 1, 0, 0, sel, dir, 0, 2'd0, loss);
  endfunction
  function automatic logic [18:0] gapv(input logic [7:0] loss, input logic [1:0] sel,
                                       input logic dir);
    return v(0, 0, 1, 0, 0, sel, dir, 1, 2'd0, loss);
  endfunction
  function automatic logic [18:0] faultv(input logic [1:0] rt);
    return v(1, 1, 0, 1, 0, 2'd0, 1, 1, rt, 8'd0);
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [31:0] at, input logic [7:0] tag, input logic [18:0] vv);
    exp_q.push_back({at, tag, vv});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [18:0]   got;
    got = {o_pll_reset, o_sys_reset, o_ready, o_fault, o_step_ready, o_phasesel,
           o_phasedir, o_phasestep, o_retry_count, o_loss_count};
    while (exp_q.size() > 0 && exp_q[0][58:27] <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e[58:27] != cyc) begin
        n_errors++;
        $display("FAIL %s: scheduled cycle %0d not sampled (now %0d)",
                 tag_name(e[26:19]), e[58:27], cyc);
      end else if (got !== e[18:0]) begin
        n_errors++;
        $display("FAIL %s @cyc %0d: got %b required %b", tag_name(e[26:19]), cyc, got, e[18:0]);
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] c, r, a, b, d, e, f, g, h, t;
    logic [7:0]  le;
    reset = 1'b1; i_locked = 1'b0; i_step_valid = 1'b0; i_step_sel = 2'd0; i_step_dir = 1'b0;
    tick(3);

    // reset values and clean bring-up
    c = cyc;
    push(c + 1, T_RST, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(1);
    r = cyc; reset = 1'b0;
    push(r + 1, T_BRING, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    push(r + 3, T_BRING, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    push(r + 4, T_BRING, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(10);
    c = cyc; i_locked = 1'b1;
    push(c + 10, T_BRING, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    push(c + 11, T_BRING, runv(8'd0, 2'd0, 1'b1));
    tick(12);

    // single phase step, inputs scrambled after acceptance
    a = cyc; i_step_valid = 1'b1; i_step_sel = 2'd1; i_step_dir = 1'b0;
    push(a + 1, T_STEP, lowv(8'd0, 2'd1, 1'b0));
    push(a + 2, T_STEP, lowv(8'd0, 2'd1, 1'b0));
    push(a + 3, T_STEP, gapv(8'd0, 2'd1, 1'b0));
    push(a + 5, T_STEP, gapv(8'd0, 2'd1, 1'b0));
    push(a + 6, T_STEP, runv(8'd0, 2'd1, 1'b0));
    tick(1);
    i_step_valid = 1'b0; i_step_sel = 2'd0; i_step_dir = 1'b1;
    tick(6);

    // back-to-back requests with valid held
    b = cyc; i_step_valid = 1'b1; i_step_sel = 2'd2; i_step_dir = 1'b1;
    push(b + 1,  T_B2B, lowv(8'd0, 2'd2, 1'b1));
    push(b + 3,  T_B2B, gapv(8'd0, 2'd2, 1'b1));
    push(b + 5,  T_B2B, gapv(8'd0, 2'd2, 1'b1));
    push(b + 6,  T_B2B, runv(8'd0, 2'd2, 1'b1));
    push(b + 7,  T_B2B, lowv(8'd0, 2'd2, 1'b1));
    push(b + 8,  T_B2B, lowv(8'd0, 2'd2, 1'b1));
    push(b + 9,  T_B2B, gapv(8'd0, 2'd2, 1'b1));
    push(b + 12, T_B2B, runv(8'd0, 2'd2, 1'b1));
    tick(7);
    i_step_valid = 1'b0; i_step_sel = 2'd0; i_step_dir = 1'b0;
    tick(6);

    // lock lost while PHASESTEP is low, then full re-sequence
    d = cyc; i_step_valid = 1'b1; i_step_sel = 2'd3; i_step_dir = 1'b0; i_locked = 1'b0;
    push(d + 1, T_LOSS, lowv(8'd0, 2'd3, 1'b0));
    push(d + 2, T_LOSS, lowv(8'd0, 2'd3, 1'b0));
    push(d + 3, T_LOSS, rstv(2'd0, 8'd1, 2'd3, 1'b0));
    push(d + 6, T_LOSS, rstv(2'd0, 8'd1, 2'd3, 1'b0));
    push(d + 7, T_LOSS, waitv(2'd0, 8'd1, 2'd3, 1'b0));
    tick(1);
    i_step_valid = 1'b0;
    tick(9);
    i_locked = 1'b1;
    push(d + 20, T_LOSS, waitv(2'd0, 8'd1, 2'd3, 1'b0));
    push(d + 21, T_LOSS, runv(8'd1, 2'd3, 1'b0));
    tick(11);

    // 255 more losses: count must stop at 255
    for (int i = 1; i <= 255; i++) begin
      e = cyc; i_locked = 1'b0;
      le = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      push(e + 3,  T_SAT, rstv(2'd0, le, 2'd3, 1'b0));
      push(e + 16, T_SAT, runv(le, 2'd3, 1'b0));
      tick(1);
      i_locked = 1'b1;
      tick(15);
    end

    // reset during PHASE_GAP
    f = cyc; i_step_valid = 1'b1; i_step_sel = 2'd1; i_step_dir = 1'b1;
    push(f + 1, T_RGAP, lowv(8'd255, 2'd1, 1'b1));
    push(f + 3, T_RGAP, gapv(8'd255, 2'd1, 1'b1));
    push(f + 4, T_RGAP, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(1);
    i_step_valid = 1'b0;
    tick(2);
    reset = 1'b1; i_locked = 1'b0;
    tick(3);

    // lock chatter: high 5, low 1, high
    g = cyc; reset = 1'b0;
    push(g + 3, T_CHAT, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    push(g + 4, T_CHAT, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(6);
    i_locked = 1'b1;
    tick(5);
    i_locked = 1'b0;
    tick(1);
    i_locked = 1'b1;
    push(g + 14, T_CHAT, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    push(g + 18, T_CHAT, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    push(g + 22, T_CHAT, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    push(g + 23, T_CHAT, runv(8'd0, 2'd0, 1'b1));
    tick(12);
    i_locked = 1'b0; reset = 1'b1;
    push(g + 25, T_RST, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(3);

    // reset during WAIT_LOCK
    h = cyc; reset = 1'b0;
    push(h + 4, T_RWAIT, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    push(h + 6, T_RWAIT, waitv(2'd0, 8'd0, 2'd0, 1'b1));
    push(h + 7, T_RWAIT, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(6);
    reset = 1'b1;
    tick(3);

    // lock never arrives: three attempts then sticky fault
    t = cyc; reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      c = t + 32'(36 * p);
      push(c + 1,  T_TMO, rstv(2'(p), 8'd0, 2'd0, 1'b1));
      push(c + 3,  T_TMO, rstv(2'(p), 8'd0, 2'd0, 1'b1));
      push(c + 4,  T_TMO, waitv(2'(p), 8'd0, 2'd0, 1'b1));
      push(c + 35, T_TMO, waitv(2'(p), 8'd0, 2'd0, 1'b1));
    end
    push(t + 108, T_FLT, faultv(2'd2));
    push(t + 150, T_FLT, faultv(2'd2));
    tick(151);
    reset = 1'b1;
    push(t + 152, T_RST, rstv(2'd0, 8'd0, 2'd0, 1'b1));
    tick(1);
    reset = 1'b0;

    // drain with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick(1);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
